adc_window_accumulator: RTL and testbench
=========================================

Name: adc_window_accumulator

Overview:
- Sample-integration stage directly upstream of the SPGD measurement sequencer.
- Sums a fixed window of 2^LOG2_N signed ADC samples and raises done when the window is complete.
- Publishes the window average into a held result register on the sequencer's reg_write strobe.
- Clears the window on the sequencer's adc_rst strobe and clears the result register on reg_rst.

Parameters:
- DW, 14, ADC sample width (two's complement).
- LOG2_N, 10, log2 of samples per window; legal range 1..16.

Ports:
- adc_clk  in  1  sampling clock; all logic on rising edge.
- adc_rstn  in  1  asynchronous active-low reset.
- enable  in  1  run gate; low clears the window and holds it idle.
- adc_dat  in  DW  signed ADC sample, one per cycle.
- adc_rst  in  1  synchronous window clear (from sequencer).
- reg_write  in  1  synchronous result-capture strobe (from sequencer).
- reg_rst  in  1  synchronous result-register clear (from sequencer).
- done  out  1  window complete; level, held until cleared.
- result  out  DW  signed window average, held.
- result_valid  out  1  one-cycle pulse, cycle after a successful capture.
- acc_out  out  DW+LOG2_N  raw signed running sum (debug).
- err  out  1  sticky protocol error.

Behaviour:
- Reset (adc_rstn=0, async): acc=0, cnt=0, done=0, result=0, result_valid=0, err=0, state=IDLE.
- Accumulator width DW+LOG2_N, sign-extended adds; overflow impossible by construction.
- Counter width LOG2_N+1, counts accepted samples 0..2^LOG2_N.
- States:
  - IDLE: entered on reset or enable=0; acc, cnt, done held at 0. Moves to ACCUM on the first cycle enable=1; no sample is taken that cycle.
  - ACCUM: each cycle acc+=adc_dat and cnt+=1. When the accepted sample makes cnt=2^LOG2_N, go to FULL.
  - FULL: done=1; further samples ignored; acc and cnt frozen.
- Latency: the sample presented on the cycle after IDLE->ACCUM is the first counted. done rises the cycle after the 2^LOG2_N-th sample is accepted, so 2^LOG2_N+1 cycles after ACCUM entry.
- adc_rst=1 (enable=1), any state: next cycle acc=0, cnt=0, done=0, state=ACCUM. The sample present during the adc_rst cycle is discarded; counting restarts with the following cycle's sample.
- reg_write=1 while done=1: result <= acc arithmetic-shifted right by LOG2_N (floor, two's complement), taking the low DW bits; result_valid=1 on the next cycle only.
- reg_write=1 while done=0: result unchanged, no result_valid pulse, err set to 1.
- reg_rst=1: next cycle result=0 and err=0.
- Simultaneous events:
  - reg_write and adc_rst in the same cycle: capture uses the pre-clear acc, then the window clears.
  - reg_write and reg_rst in the same cycle: reg_rst wins; result=0, no pulse, err=0.
  - enable=0 with any strobe: window clears to IDLE; reg_write/reg_rst still act on result and err.
- enable falling mid-window: next cycle IDLE, partial sum discarded, done=0. result is untouched.
- acc_out mirrors acc combinationally from the register; done is registered, with no combinational path from inputs.

Test Plan:
- LOG2_N=2; enable=1; samples 100,200,300,400 -> done=1 on the cycle after the 4th sample; acc_out=1000; reg_write -> result=250, result_valid pulses exactly one cycle.
- LOG2_N=2; samples -1,-2,-2,-2 (sum -7) -> reg_write gives result=-2 (floor); in FULL, extra samples of 5000 leave acc_out=-7.
- Window complete, then adc_rst -> next cycle done=0, acc_out=0. With sample 77 during the adc_rst cycle and then 1,1,1,1, done re-asserts with acc_out=4 (77 discarded).
- reg_write asserted at cnt=2 (done=0) -> result unchanged, err=1, no pulse; reg_rst -> err=0, result=0. reg_write+reg_rst in the same cycle with done=1 -> result=0, no pulse.
- enable dropped after 3 of 4 samples -> IDLE next cycle, acc_out=0, done=0. Re-enable -> one idle cycle, then a full fresh window of 4 samples before done.
- adc_rstn pulsed low mid-window, asynchronously between edges -> all outputs 0 immediately. After release with enable=1, accumulation resumes per latency rule.

Source files
------------

// File: rtl/adc_window_accumulator_if.sv
// Sequencer <-> sample-integration interface for adc_window_accumulator.
// The sequencer side (master) drives samples and strobes; the accumulator
// side (slave) returns window status, the held average and debug sum.
interface adc_window_accumulator_if #(
    parameter int DW     = 14,
    parameter int LOG2_N = 10
) ();
    logic                         enable;
    logic signed [DW-1:0]         adc_dat;
    logic                         adc_rst;
    logic                         reg_write;
    logic                         reg_rst;
    logic                         done;
    logic signed [DW-1:0]         result;
    logic                         result_valid;
    logic signed [DW+LOG2_N-1:0]  acc_out;
    logic                         err;

    modport master (
        output enable, adc_dat, adc_rst, reg_write, reg_rst,
        input  done, result, result_valid, acc_out, err
    );

    modport slave (
        input  enable, adc_dat, adc_rst, reg_write, reg_rst,
        output done, result, result_valid, acc_out, err
    );
endinterface

// File: rtl/adc_window_accumulator.sv
// Sums a window of 2^LOG2_N signed ADC samples, flags completion with a
// held done level, and publishes the floor average into a held result
// register when the sequencer strobes reg_write.
module adc_window_accumulator #(
    parameter int DW     = 14,
    parameter int LOG2_N = 10
) (
    input  logic                  adc_clk,
    input  logic                  adc_rstn,
    adc_window_accumulator_if.slave bus
);
    localparam int AW = DW + LOG2_N;
    localparam int CW = LOG2_N + 1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << LOG2_N) - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                state;
    logic signed [AW-1:0]  acc;
    logic        [CW-1:0]  cnt;
    logic                  done_r;
    logic signed [DW-1:0]  result_r;
    logic                  result_valid_r;
    logic                  err_r;
    logic signed [AW-1:0]  sample_ext;

    // Floor average: arithmetic shift keeps two's-complement rounding
    // toward minus infinity; the average always fits back into DW bits.
    function automatic logic signed [DW-1:0] window_avg(input logic signed [AW-1:0] sum);
        logic signed [AW-1:0] shifted;
        shifted = sum >>> LOG2_N;
        return shifted[DW-1:0];
    endfunction

    assign sample_ext = {{LOG2_N{bus.adc_dat[DW-1]}}, bus.adc_dat};

    // Window FSM: enable gates everything, adc_rst restarts the window
    // (discarding the current sample), FULL freezes the sum until cleared.
    always_ff @(posedge adc_clk or negedge adc_rstn) begin
        if (!adc_rstn) begin
            state  <= IDLE;
            acc    <= '0;
            cnt    <= '0;
            done_r <= 1'b0;
        end else if (!bus.enable) begin
            state  <= IDLE;
            acc    <= '0;
            cnt    <= '0;
            done_r <= 1'b0;
        end else if (bus.adc_rst) begin
            state  <= ACCUM;
            acc    <= '0;
            cnt    <= '0;
            done_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= ACCUM;
                end
                ACCUM: begin
                    acc <= acc + sample_ext;
                    cnt <= cnt + CNT_ONE;
                    if (cnt == CNT_LAST) begin
                        state  <= FULL;
                        done_r <= 1'b1;
                    end
                end
                FULL: begin
                    done_r <= 1'b1;
                end
                default: begin
                    state  <= IDLE;
                    acc    <= '0;
                    cnt    <= '0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    // Result register: reg_rst has priority; a capture without a complete
    // window is a sequencing error and leaves the published value alone.
    always_ff @(posedge adc_clk or negedge adc_rstn) begin
        if (!adc_rstn) begin
            result_r       <= '0;
            result_valid_r <= 1'b0;
            err_r          <= 1'b0;
        end else if (bus.reg_rst) begin
            result_r       <= '0;
            result_valid_r <= 1'b0;
            err_r          <= 1'b0;
        end else if (bus.reg_write) begin
            if (done_r) begin
                result_r       <= window_avg(acc);
                result_valid_r <= 1'b1;
            end else begin
                result_valid_r <= 1'b0;
                err_r          <= 1'b1;
            end
        end else begin
            result_valid_r <= 1'b0;
        end
    end

    assign bus.done         = done_r;
    assign bus.result       = result_r;
    assign bus.result_valid = result_valid_r;
    assign bus.acc_out      = acc;
    assign bus.err          = err_r;

endmodule

// File: tb/tb_adc_window_accumulator.sv
// Scoreboard bench for adc_window_accumulator (LOG2_N=2). The stimulus
// process advances a window model (a queue of accepted samples) and pushes
// the expected post-edge outputs; the monitor pops and compares them.
module tb_adc_window_accumulator;
    localparam int DW     = 14;
    localparam int LOG2_N = 2;
    localparam int NS     = 1 << LOG2_N;

    typedef struct {
        bit done;
        int acc;
        bit err;
        int res;
        bit rv;
    } exp_t;

    logic adc_clk;
    logic adc_rstn;

    adc_window_accumulator_if #(.DW(DW), .LOG2_N(LOG2_N)) bus ();

    adc_window_accumulator #(.DW(DW), .LOG2_N(LOG2_N)) dut (
        .adc_clk  (adc_clk),
        .adc_rstn (adc_rstn),
        .bus      (bus)
    );

    exp_t exp_q[$];
    int   cap_q[$];

    // model state
    bit m_run;
    int m_win[$];
    int m_res;
    bit m_err;
    bit m_rv;

    int nvec = 0;
    int nerr = 0;

    initial begin
        adc_clk = 1'b0;
        forever #5 adc_clk = ~adc_clk;
    end

    function automatic int floor_avg(input int s);
        if (s >= 0) return s / NS;
        return -((-s + NS - 1) / NS);
    endfunction

    function automatic int win_sum();
        int s = 0;
        foreach (m_win[i]) s += m_win[i];
        return s;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 1'b0;
        m_win.delete();
        m_res = 0;
        m_err = 1'b0;
        m_rv  = 1'b0;
    endtask

    // One clock of stimulus: predict, queue expectations, drive, clock.
    task automatic cycle(input bit en, input int dat, input bit ar, input bit rw, input bit rr);
        bit   pre_done;
        int   pre_sum;
        exp_t e;
        pre_done = (m_win.size() == NS);
        pre_sum  = win_sum();
        if (rr) begin
            m_res = 0; m_err = 1'b0; m_rv = 1'b0;
        end else if (rw) begin
            if (pre_done) begin
                m_res = floor_avg(pre_sum);
                m_rv  = 1'b1;
                cap_q.push_back(m_res);
            end else begin
                m_err = 1'b1; m_rv = 1'b0;
            end
        end else begin
            m_rv = 1'b0;
        end
        if (!en) begin
            m_run = 1'b0; m_win.delete();
        end else if (ar) begin
            m_run = 1'b1; m_win.delete();
        end else if (!m_run) begin
            m_run = 1'b1;
        end else if (m_win.size() < NS) begin
            m_win.push_back(dat);
        end
        e.done = (m_win.size() == NS);
        e.acc  = win_sum();
        e.err  = m_err;
        e.res  = m_res;
        e.rv   = m_rv;
        exp_q.push_back(e);
        bus.enable    = en;
        bus.adc_dat   = dat[DW-1:0];
        bus.adc_rst   = ar;
        bus.reg_write = rw;
        bus.reg_rst   = rr;
        @(posedge adc_clk);
        #1;
    endtask

    // Monitor: per-cycle scoreboard at the falling edge; async reset
    // checked shortly after the reset edge.
    always begin
        @(negedge adc_clk or negedge adc_rstn);
        if (!adc_rstn) begin
            #1;
            check("rst_done", int'(bus.done), 0);
            check("rst_acc", int'(bus.acc_out), 0);
            check("rst_result", int'(bus.result), 0);
            check("rst_rv", int'(bus.result_valid), 0);
            check("rst_err", int'(bus.err), 0);
        end else if (exp_q.size() > 0) begin
            exp_t e;
            int   a;
            int   r;
            e = exp_q.pop_front();
            a = $signed(bus.acc_out);
            r = $signed(bus.result);
            check("done", int'(bus.done), int'(e.done));
            check("acc_out", a, e.acc);
            check("err", int'(bus.err), int'(e.err));
            check("result", r, e.res);
            check("result_valid", int'(bus.result_valid), int'(e.rv));
            if (bus.result_valid) begin
                if (cap_q.size() == 0) check("capture_pending", 0, 1);
                else check("capture_value", r, cap_q.pop_front());
            end
        end
    end

    initial begin
        bus.enable = 1'b0; bus.adc_dat = '0; bus.adc_rst = 1'b0;
        bus.reg_write = 1'b0; bus.reg_rst = 1'b0;
        adc_rstn = 1'b1;
        model_reset();
        #2 adc_rstn = 1'b0;
        repeat (2) @(posedge adc_clk);
        @(negedge adc_clk);
        #2 adc_rstn = 1'b1;

        // basic window and capture
        cycle(1, 0, 0, 0, 0);
        cycle(1, 100, 0, 0, 0); cycle(1, 200, 0, 0, 0);
        cycle(1, 300, 0, 0, 0); cycle(1, 400, 0, 0, 0);
        cycle(1, 0, 0, 1, 0);
        cycle(1, 0, 0, 0, 0); cycle(1, 0, 0, 0, 0);

        // negative floor and frozen FULL
        cycle(1, 0, 1, 0, 0);
        cycle(1, -1, 0, 0, 0); cycle(1, -2, 0, 0, 0);
        cycle(1, -2, 0, 0, 0); cycle(1, -2, 0, 0, 0);
        cycle(1, 5000, 0, 0, 0); cycle(1, 5000, 0, 1, 0);
        cycle(1, 5000, 0, 0, 0);

        // adc_rst discards its sample
        cycle(1, 77, 1, 0, 0);
        for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0, 0);
        cycle(1, 9, 0, 0, 0);

        // capture without done, reg_rst, simultaneous strobes
        cycle(1, 0, 1, 0, 0);
        cycle(1, 10, 0, 0, 0); cycle(1, 20, 0, 1, 0);
        cycle(1, 30, 0, 0, 0); cycle(1, 40, 0, 0, 1);
        cycle(1, 0, 0, 1, 1); cycle(1, 0, 0, 1, 1);
        cycle(1, 0, 0, 1, 1);
        cycle(1, 0, 0, 1, 0);
        cycle(1, 8, 1, 1, 0);

        // enable drop mid-window, then re-enable
        cycle(1, 0, 1, 0, 0);
        cycle(1, 11, 0, 0, 0); cycle(1, 12, 0, 0, 0); cycle(1, 13, 0, 0, 0);
        cycle(0, 14, 0, 0, 0);
        cycle(1, 15, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(1, 3 * i - 4, 0, 0, 0);
        cycle(0, 0, 0, 1, 0);

        // async reset mid-window
        cycle(1, 0, 0, 0, 0); cycle(1, 5, 0, 0, 0); cycle(1, 6, 0, 0, 0);
        @(negedge adc_clk);
        #2 adc_rstn = 1'b0;
        model_reset();
        bus.enable = 1'b1;
        @(posedge adc_clk);
        @(negedge adc_clk);
        #2 adc_rstn = 1'b1;
        for (int i = 0; i < 6; i++) cycle(1, 7 - i, 0, 0, 0);
        cycle(1, 0, 0, 1, 0);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            bit en;
            bit ar;
            bit rw;
            bit rr;
            int dat;
            en  = ($urandom_range(0, 99) < 96);
            ar  = ($urandom_range(0, 99) < 4);
            rw  = ($urandom_range(0, 99) < 15);
            rr  = ($urandom_range(0, 99) < 4);
            dat = int'($urandom_range(0, 16383)) - 8192;
            cycle(en, dat, ar, rw, rr);
        end

        repeat (3) @(posedge adc_clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
